// File: rtl/ram_dma_if.sv
// RAM port bundle between the block-copy engine (master) and a single-port
// synchronous RAM (slave). Handshake: a request exists only in a cycle with
// mem_cs=1. mem_write=1 writes mem_wdata to mem_addr at that edge;
// mem_write=0 reads, and mem_rdata holds the word in the following cycle.
// There is no back-pressure; the RAM accepts every request.
interface ram_dma_if #(
  parameter int A = 10,
  parameter int D = 8
);
  logic         mem_cs;
  logic         mem_write;
  logic [A-1:0] mem_addr;
  logic [D-1:0] mem_wdata;
  logic [D-1:0] mem_rdata;

  modport master (
    output mem_cs,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_cs,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ram_dma.sv
// ram_dma: copies len words from src_addr to dst_addr inside one RAM,
// one read then one write per word (2 cycles/word), addresses modulo 2^A.
// Optional feature macro RAM_DMA_FILL_EN: adds fill/fill_value ports and a
// FILL state that writes a constant at 1 cycle/word without reading.
// dbg_state_o exposes the FSM state for observation.
module ram_dma #(
  parameter int A = 10,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [A-1:0] src_addr,
  input  logic [A-1:0] dst_addr,
  input  logic [A:0]   len,
`ifdef RAM_DMA_FILL_EN
  input  logic         fill,
  input  logic [D-1:0] fill_value,
`endif
  output logic         busy,
  output logic         done,
  output logic [2:0]   dbg_state_o,
  ram_dma_if.master    bus
);

  typedef enum logic [2:0] {
`ifdef RAM_DMA_FILL_EN
    S_FILL = 3'd4,
`endif
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd3
  } state_t;

  state_t       state_q, state_d;
  logic [A-1:0] src_q, src_d;
  logic [A-1:0] dst_q, dst_d;
  logic [A:0]   len_q, len_d;
  logic [A:0]   i_q, i_d;
  logic [A:0]   i_inc;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         cs_q, cs_d;
  logic         write_q, write_d;
  logic [A-1:0] addr_q, addr_d;
`ifdef RAM_DMA_FILL_EN
  logic         fill_q, fill_d;
  logic [D-1:0] fv_q, fv_d;
`endif

  // State and registered RAM-port/status outputs; reset aborts any transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
`ifdef RAM_DMA_FILL_EN
      fill_q  <= 1'b0;
      fv_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      write_q <= write_d;
      addr_q  <= addr_d;
`ifdef RAM_DMA_FILL_EN
      fill_q  <= fill_d;
      fv_q    <= fv_d;
`endif
    end
  end

  // Next-state logic: each state schedules the RAM request for the next cycle.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    i_d     = i_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_d    = cs_q;
    write_d = write_q;
    addr_d  = addr_q;
`ifdef RAM_DMA_FILL_EN
    fill_d  = fill_q;
    fv_d    = fv_q;
`endif
    i_inc   = i_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_d  = src_addr;
            dst_d  = dst_addr;
            len_d  = len;
            i_d    = '0;
            busy_d = 1'b1;
            cs_d   = 1'b1;
`ifdef RAM_DMA_FILL_EN
            fill_d = fill;
            fv_d   = fill_value;
            if (fill) begin
              write_d = 1'b1;
              addr_d  = dst_addr;
              state_d = S_FILL;
            end else
`endif
            begin
              write_d = 1'b0;
              addr_d  = src_addr;
              state_d = S_RD;
            end
          end else begin
            // Zero-length request: acknowledge without touching the RAM.
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RD: begin
        cs_d    = 1'b1;
        write_d = 1'b1;
        addr_d  = dst_q + i_q[A-1:0];
        state_d = S_WR;
      end
      S_WR: begin
        i_d = i_inc;
        if (i_inc < len_q) begin
          cs_d    = 1'b1;
          write_d = 1'b0;
          addr_d  = src_q + i_inc[A-1:0];
          state_d = S_RD;
        end else begin
          cs_d    = 1'b0;
          write_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
`ifdef RAM_DMA_FILL_EN
      S_FILL: begin
        i_d = i_inc;
        if (i_inc < len_q) begin
          addr_d = dst_q + i_inc[A-1:0];
        end else begin
          cs_d    = 1'b0;
          write_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign dbg_state_o   = state_q;
  assign bus.mem_cs    = cs_q;
  assign bus.mem_write = write_q;
  assign bus.mem_addr  = addr_q;

  // Write data forwards the word read in the previous cycle (or the fill value).
`ifdef RAM_DMA_FILL_EN
  assign bus.mem_wdata = (cs_q & write_q) ? (fill_q ? fv_q : bus.mem_rdata) : '0;
`else
  assign bus.mem_wdata = (cs_q & write_q) ? bus.mem_rdata : '0;
`endif

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: RAM model on the slave modport, table of copy vectors
// with a reference memory image, plus hand sequences for zero length,
// mid-transfer reset and start pulses while busy.
module tb_ram_dma;
  localparam int A = 10;
  localparam int D = 8;
  localparam int N = 1 << A;

  typedef struct {
    string        name;
    logic [A-1:0] src;
    logic [A-1:0] dst;
    logic [A:0]   len;
    bit           fl;
    logic [D-1:0] fv;
    int           exp_busy;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [A-1:0] src_addr = '0;
  logic [A-1:0] dst_addr = '0;
  logic [A:0]   len = '0;
`ifdef RAM_DMA_FILL_EN
  logic         fill = 1'b0;
  logic [D-1:0] fill_value = '0;
`endif
  logic         busy;
  logic         done;
  logic [2:0]   dbg_state;

  ram_dma_if #(.A(A), .D(D)) bus ();

  ram_dma #(.A(A), .D(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
`ifdef RAM_DMA_FILL_EN
    .fill       (fill),
    .fill_value (fill_value),
`endif
    .busy       (busy),
    .done       (done),
    .dbg_state_o(dbg_state),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [D-1:0] ram [N];
  logic         pl_we = 1'b0;
  logic [A-1:0] pl_addr = '0;
  logic [D-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (bus.mem_cs) begin
      if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // ---------------- monitor ----------------
  int           busy_cyc = 0;
  int           done_cnt = 0;
  int           cs_cnt = 0;
  logic [A-1:0] rd_log[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (bus.mem_cs) cs_cnt++;
      if (bus.mem_cs && !bus.mem_write) rd_log.push_back(bus.mem_addr);
    end
  end

  // ---------------- scoreboard ----------------
  logic [D-1:0] exp_mem [N];
  logic [A-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_mem(input string nm);
    int bad = -1;
    for (int k = 0; k < N; k++)
      if (ram[k] !== exp_mem[k] && bad < 0) bad = k;
    n_cmp++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: ram[%0h] got %0h expected %0h", nm, bad, ram[bad], exp_mem[bad]);
    end
  endtask

  task automatic model_copy(input logic [A-1:0] s, input logic [A-1:0] d, input int n);
    logic [A-1:0] sa, da;
    for (int k = 0; k < n; k++) begin
      sa = s + k[A-1:0];
      da = d + k[A-1:0];
      exp_mem[da] = exp_mem[sa];
    end
  endtask

  task automatic model_fill(input logic [A-1:0] d, input int n, input logic [D-1:0] v);
    logic [A-1:0] da;
    for (int k = 0; k < n; k++) begin
      da = d + k[A-1:0];
      exp_mem[da] = v;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic poke(input logic [A-1:0] a, input logic [D-1:0] v);
    pl_we = 1'b1; pl_addr = a; pl_data = v;
    exp_mem[a] = v;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic set_inputs(input logic [A-1:0] s, input logic [A-1:0] d, input logic [A:0] n,
                            input bit fl, input logic [D-1:0] fv);
    src_addr = s; dst_addr = d; len = n;
`ifdef RAM_DMA_FILL_EN
    fill = fl; fill_value = fv;
`else
    if (fl || fv != '0) $display("note: fill vector ignored in copy-only build");
`endif
  endtask

  task automatic pulse_start(input logic [A-1:0] s, input logic [A-1:0] d, input logic [A:0] n,
                             input bit fl, input logic [D-1:0] fv);
    @(posedge clk); #1;
    set_inputs(s, d, n, fl, fv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns #1 after the edge that closes the DONE cycle.
  task automatic wait_done(input string nm, input int budget);
    int c = 0;
    bit seen = 0;
    while (!seen && c < budget) begin
      @(negedge clk);
      if (done) seen = 1;
      c++;
    end
    check({nm, " done_seen"}, {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    int b0, d0, r0, bad;
    b0 = busy_cyc; d0 = done_cnt; r0 = rd_log.size();
    pulse_start(v.src, v.dst, v.len, v.fl, v.fv);
    wait_done(v.name, 3 * N + 10);
    if (v.fl) model_fill(v.dst, int'(v.len), v.fv);
    else model_copy(v.src, v.dst, int'(v.len));
    check_mem({v.name, " mem"});
    check({v.name, " busy_cycles"}, busy_cyc - b0, v.exp_busy);
    check({v.name, " done_pulses"}, done_cnt - d0, 1);
    exp_q.delete();
    if (!v.fl)
      for (int k = 0; k < int'(v.len); k++) exp_q.push_back(v.src + k[A-1:0]);
    check({v.name, " read_count"}, rd_log.size() - r0, exp_q.size());
    bad = 0;
    for (int k = 0; k < exp_q.size() && r0 + k < rd_log.size(); k++)
      if (rd_log[r0 + k] !== exp_q[k]) bad++;
    check({v.name, " read_order"}, bad, 0);
    check({v.name, " idle_after"}, {28'd0, dbg_state, bus.mem_cs}, 32'd0);
  endtask

  // ---------------- test ----------------
  vec_t vecs[$];

  initial begin
    int b0, d0, c0;
    vec_t v;

    vecs.push_back('{"copy4",     10'h010, 10'h020, 11'd4,    1'b0, 8'h00, 8});
    vecs.push_back('{"wrap_src",  10'h3FE, 10'h100, 11'd4,    1'b0, 8'h00, 8});
    vecs.push_back('{"memmove",   10'h052, 10'h050, 11'd6,    1'b0, 8'h00, 12});
    vecs.push_back('{"replicate", 10'h060, 10'h061, 11'd5,    1'b0, 8'h00, 10});
    vecs.push_back('{"one_wrap",  10'h3FF, 10'h000, 11'd1,    1'b0, 8'h00, 2});
    vecs.push_back('{"full_ram",  10'h005, 10'h000, 11'd1024, 1'b0, 8'h00, 2048});
`ifdef RAM_DMA_FILL_EN
    vecs.push_back('{"fill3",     10'h000, 10'h040, 11'd3,    1'b1, 8'h5A, 3});
`endif

    // Preload under reset, then check reset values.
    for (int k = 0; k < N; k++) poke(k[A-1:0], 8'((k * 37 + 11) & 8'hFF));
    poke(10'h010, 8'hAA); poke(10'h011, 8'hBB); poke(10'h012, 8'hCC); poke(10'h013, 8'hDD);
    check("reset outputs", {busy, done, bus.mem_cs, bus.mem_write, dbg_state}, 32'd0);
    check("reset addr_wdata", {bus.mem_addr, bus.mem_wdata}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("idle outputs", {busy, done, bus.mem_cs, dbg_state}, 32'd0);

    // Table-driven transfers.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Zero length: done next cycle, no RAM access, busy never set.
    b0 = busy_cyc; d0 = done_cnt; c0 = cs_cnt;
    pulse_start(10'h030, 10'h031, 11'd0, 1'b0, 8'h00);
    wait_done("len0", 10);
    check("len0 busy_cycles", busy_cyc - b0, 0);
    check("len0 cs_cycles", cs_cnt - c0, 0);
    check("len0 done_pulses", done_cnt - d0, 1);
    check_mem("len0 mem");

    // Reset after the third word's write is issued but before it is sampled.
    pulse_start(10'h080, 10'h090, 11'd8, 1'b0, 8'h00);
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset outputs", {busy, done, bus.mem_cs, bus.mem_write, dbg_state}, 32'd0);
    check("midreset addr_wdata", {bus.mem_addr, bus.mem_wdata}, 32'd0);
    model_copy(10'h080, 10'h090, 2);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_mem("midreset mem");
    v = '{"after_reset", 10'h0A0, 10'h0B0, 11'd3, 1'b0, 8'h00, 6};
    run_vec(v);

    // start held through busy and DONE with changing operands: only one transfer.
    b0 = busy_cyc; d0 = done_cnt;
    @(posedge clk); #1;
    set_inputs(10'h200, 10'h280, 11'd3, 1'b0, 8'h00);
    start = 1'b1;
    @(posedge clk); #1;
    set_inputs(10'h000, 10'h300, 11'd2, 1'b0, 8'h00);
    wait_done("busy_start", 50);
    start = 1'b0;
    repeat (6) @(posedge clk); #1;
    model_copy(10'h200, 10'h280, 3);
    check_mem("busy_start mem");
    check("busy_start busy_cycles", busy_cyc - b0, 6);
    check("busy_start done_pulses", done_cnt - d0, 1);
    check("busy_start idle", {29'd0, dbg_state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
